// File: rtl/encoder_4_2_rr_if.sv
// Request/code handshake bundle for the round-robin 4-to-2 encoder.
// The master drives capture enable, requests and ready; the slave presents the code.
interface encoder_4_2_rr_if;
    logic       en;
    logic [3:0] in;
    logic       ready;
    logic [1:0] out;
    logic       valid;
    logic [3:0] pend;
    logic       dup;

    modport master (output en, in, ready, input out, valid, pend, dup);
    modport slave  (input en, in, ready, output out, valid, pend, dup);
endinterface

// File: rtl/encoder_4_2_rr.sv
// Round-robin 4-to-2 encoder: requests accumulate in a pending vector and are
// presented one code at a time through a valid/ready output register.
module encoder_4_2_rr (
    input  logic              clk,
    input  logic              rst,
    encoder_4_2_rr_if.slave   bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [1:0] out_q, out_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [3:0] pend_q, pend_nxt;
    logic       dup_q, dup_nxt;

    logic       load;
    logic       found;
    logic [1:0] k;
    logic [1:0] idx;
    logic [3:0] clr;
    logic [3:0] cap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            out_q  <= 2'b00;
            ptr    <= 2'b00;
            pend_q <= 4'b0000;
            dup_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            out_q  <= out_nxt;
            ptr    <= ptr_nxt;
            pend_q <= pend_nxt;
            dup_q  <= dup_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_nxt   = out_q;
        ptr_nxt   = ptr;
        found     = 1'b0;
        k         = 2'b00;
        idx       = 2'b00;
        clr       = 4'b0000;

        // Scan the registered pending vector cyclically from ptr; pend[3-k] holds code k.
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && pend_q[2'd3 - idx]) begin
                found = 1'b1;
                k     = idx;
            end
        end

        load = found && ((state == EMPTY) || bus.ready);

        if (load) begin
            state_nxt = FULL;
            out_nxt   = k;
            ptr_nxt   = k + 2'd1;
            clr       = 4'b1000 >> k;
        end else if ((state == FULL) && bus.ready) begin
            state_nxt = EMPTY;
        end

        // A bit re-requested in the same cycle it is loaded survives and is not a duplicate.
        cap      = bus.en ? bus.in : 4'b0000;
        pend_nxt = (pend_q & ~clr) | cap;
        dup_nxt  = |(cap & pend_q & ~clr);
    end

    assign bus.out   = out_q;
    assign bus.valid = (state == FULL);
    assign bus.pend  = pend_q;
    assign bus.dup   = dup_q;
endmodule

// File: tb/tb_encoder_4_2_rr.sv
// Directed bench for encoder_4_2_rr with hand-computed expected responses.
module tb_encoder_4_2_rr;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    encoder_4_2_rr_if bus ();

    encoder_4_2_rr dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there after the rising edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.in = 4'b1111;
        bus.ready = 1'b0;
        @(negedge clk);
        step();
        chk("rst_out",   8'(bus.out),   8'h0);
        chk("rst_valid", 8'(bus.valid), 8'h0);
        chk("rst_pend",  8'(bus.pend),  8'h0);
        chk("rst_dup",   8'(bus.dup),   8'h0);
        rst = 1'b0;

        // en=0 must ignore all-ones requests
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ign_valid", 8'(bus.valid), 8'h0);
            chk("ign_pend",  8'(bus.pend),  8'h0);
            chk("ign_dup",   8'(bus.dup),   8'h0);
        end

        // Single pulses one cycle apart, ready=1: codes 0..3 two edges after each pulse
        bus.en = 1'b1;
        bus.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in = 4'b1000 >> i;
            step();
            if (i >= 1) begin
                chk("seq_out",   8'(bus.out),   8'(i - 1));
                chk("seq_valid", 8'(bus.valid), 8'h1);
            end
        end
        bus.in = 4'b0000;
        step();
        chk("seq_out3",   8'(bus.out),   8'h3);
        chk("seq_valid3", 8'(bus.valid), 8'h1);
        step();
        chk("seq_empty", 8'(bus.valid), 8'h0);
        chk("seq_hold",  8'(bus.out),   8'h3);

        // All four at once with ready=0, then drain in round-robin order
        do_reset();
        bus.ready = 1'b0;
        bus.en = 1'b1;
        bus.in = 4'b1111;
        step();
        chk("all_pend", 8'(bus.pend), 8'hf);
        bus.en = 1'b0;
        bus.in = 4'b0000;
        step();
        chk("all_out0",   8'(bus.out),   8'h0);
        chk("all_valid0", 8'(bus.valid), 8'h1);
        chk("all_pend0",  8'(bus.pend),  8'h7);
        step();
        chk("all_stall", 8'(bus.out), 8'h0);
        chk("all_stall_pend", 8'(bus.pend), 8'h7);
        bus.ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            chk("all_out",   8'(bus.out),   8'(i));
            chk("all_valid", 8'(bus.valid), 8'h1);
        end
        step();
        chk("all_empty", 8'(bus.valid), 8'h0);

        // Duplicate detection with code 01 stalled
        do_reset();
        bus.ready = 1'b0;
        bus.en = 1'b1;
        bus.in = 4'b0100;
        step();
        bus.en = 1'b0;
        bus.in = 4'b0000;
        step();
        chk("dup_out", 8'(bus.out), 8'h1);
        bus.en = 1'b1;
        bus.in = 4'b0100;
        step();
        chk("dup_first", 8'(bus.dup), 8'h0);
        step();
        chk("dup_second", 8'(bus.dup),  8'h1);
        chk("dup_pend",   8'(bus.pend), 8'h4);
        chk("dup_hold",   8'(bus.out),  8'h1);
        bus.en = 1'b0;
        bus.in = 4'b0000;
        step();
        chk("dup_pulse", 8'(bus.dup), 8'h0);

        // Round-robin from ptr=2: in=1001 delivers 11 before 00
        do_reset();
        bus.ready = 1'b1;
        bus.en = 1'b1;
        bus.in = 4'b0100;
        step();
        bus.en = 1'b0;
        bus.in = 4'b0000;
        step();
        chk("rr_pre", 8'(bus.out), 8'h1);
        step();
        chk("rr_empty", 8'(bus.valid), 8'h0);
        bus.en = 1'b1;
        bus.in = 4'b1001;
        step();
        bus.en = 1'b0;
        bus.in = 4'b0000;
        step();
        chk("rr_first",  8'(bus.out),  8'h3);
        chk("rr_pend",   8'(bus.pend), 8'h8);
        // Re-assert bit 3 on the very edge that loads it
        bus.en = 1'b1;
        bus.in = 4'b1000;
        step();
        chk("rr_second", 8'(bus.out),  8'h0);
        chk("sc_pend",   8'(bus.pend), 8'h8);
        chk("sc_dup",    8'(bus.dup),  8'h0);
        bus.en = 1'b0;
        bus.in = 4'b0000;
        step();
        chk("sc_again", 8'(bus.out),   8'h0);
        chk("sc_valid", 8'(bus.valid), 8'h1);
        chk("sc_clear", 8'(bus.pend),  8'h0);

        // Asynchronous reset mid-operation
        do_reset();
        bus.ready = 1'b0;
        bus.en = 1'b1;
        bus.in = 4'b0100;
        step();
        bus.en = 1'b0;
        bus.in = 4'b0000;
        step();
        bus.en = 1'b1;
        bus.in = 4'b1010;
        step();
        chk("ar_pre_pend",  8'(bus.pend),  8'ha);
        chk("ar_pre_valid", 8'(bus.valid), 8'h1);
        chk("ar_pre_out",   8'(bus.out),   8'h1);
        bus.en = 1'b0;
        bus.in = 4'b0000;
        rst = 1'b1;
        #1;
        chk("ar_out",   8'(bus.out),   8'h0);
        chk("ar_valid", 8'(bus.valid), 8'h0);
        chk("ar_pend",  8'(bus.pend),  8'h0);
        chk("ar_dup",   8'(bus.dup),   8'h0);
        #3;
        rst = 1'b0;
        bus.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ar_idle_valid", 8'(bus.valid), 8'h0);
            chk("ar_idle_pend",  8'(bus.pend),  8'h0);
        end
        bus.en = 1'b1;
        bus.in = 4'b0010;
        step();
        bus.en = 1'b0;
        bus.in = 4'b0000;
        step();
        chk("ar_new_out",   8'(bus.out),   8'h2);
        chk("ar_new_valid", 8'(bus.valid), 8'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
